branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumer end of the D-stage comparator interface.
- Drives the comparator's zero-select (`cmp_zero`), receives its 3-bit one-hot result (`cmp_out` = {gt,eq,lt}), and decides whether branches and jumps are taken.
- Owns the fetch PC register and tracks delay-slot status.
- Keeps saturating branch statistics counters.
- Sits between the F and D stages of the 5-stage MIPS pipeline, alongside the hazard unit.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall; freezes the F/D advance
br_op  input  4  D-stage control op: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr; 11-15 treated as none
pc_D  input  32  PC of the instruction in D
imm16  input  16  branch offset field
idx26  input  26  jump index field
rs_val  input  32  forwarded rs value, used as the jr/jalr target
cmp_zero  output  1  to comparator: 1 forces operand B to 0
cmp_out  input  3  from comparator: 100 gt, 010 eq, 001 lt (signed)
pc_F  output  32  current fetch PC (registered)
taken  output  1  combinational: D-stage redirect this cycle
link_pc  output  32  pc_D + 8, for jal/jalr
is_ds  output  1  registered: instruction now in D is a delay slot
cmp_err  output  1  sticky: illegal cmp_out seen on a conditional branch
ds_err  output  1  sticky: control op found in a delay slot
br_cnt  output  CNT_W  count of conditional branches resolved
tk_cnt  output  CNT_W  count of conditional branches taken

Behaviour:
- Reset, taking priority over everything:
  - pc_F = PC_RESET.
  - is_ds, cmp_err, ds_err, br_cnt, tk_cnt = 0.
  - A reset asserted mid-stall behaves identically.
- cmp_zero = 1 for br_op 3-6; 0 otherwise. It is combinational and has zero latency to the comparator.
- cmp_out legality: one-hot encodings are legal; 000 or any multi-hot value is illegal.
- Taken conditions:
  - Conditional ops:
    - beq: eq
    - bne: legal and !eq
    - blez: lt|eq
    - bgtz: gt
    - bltz: lt
    - bgez: gt|eq
  - Ops 7-10 are always taken.
  - An illegal cmp_out on ops 1-6 forces not-taken.
- Targets:
  - Branch: pc_D + 4 + (sign-extended imm16 << 2), mod 2^32. Wrap-around is allowed and is not flagged.
  - j/jal: {(pc_D+4)[31:28], idx26, 2'b00}.
  - jr/jalr: rs_val, used unmodified.
- link_pc = pc_D + 8, mod 2^32, for all br_op values.
- PC update on each rising clk edge:
  - If reset: load PC_RESET.
  - Else if stall: hold pc_F.
  - Else if taken: load the target.
  - Else: pc_F + 4.
- Redirect latency:
  - A decision is made in the cycle the op sits in D with stall = 0.
  - The target appears on pc_F on the next edge.
  - The instruction at pc_D + 4 (the delay slot) is always executed; this block never flushes.
- While stall = 1, `taken` is still driven, but no register changes: no PC change, no counter change, no is_ds update, no error capture.
- is_ds:
  - On a non-stalled edge: is_ds <= (br_op in 1..10).
  - On a stalled edge: hold.
- ds_err:
  - Set on a non-stalled edge when is_ds = 1 and br_op is in 1..10.
  - The op is still resolved normally.
  - Cleared only by reset.
- cmp_err:
  - Set on a non-stalled edge when br_op is in 1..6 and cmp_out is illegal.
  - Cleared only by reset.
- Counters, updated on non-stalled edges only:
  - br_cnt +1 for ops 1-6.
  - tk_cnt +1 for ops 1-6 that are taken.
  - Both saturate at 2^CNT_W - 1 and never wrap.
  - tk_cnt <= br_cnt always holds.
- Both error flags may be set on the same edge.

Test Plan:
- Reset check:
  - Stimulus: reset = 1 for 2 cycles, then release with br_op = 0 and no stall for 3 cycles.
  - Required: pc_F = 3000, 3004, 3008, 300C; all flags and counters 0.
- beq taken / bne not taken:
  - beq taken stimulus: pc_D = 00003010, imm16 = FFFC, cmp_out = 010, br_op = 1.
  - Required: taken = 1 and cmp_zero = 0; next pc_F = 00003004; is_ds = 1 next cycle; br_cnt = 1, tk_cnt = 1.
  - bne stimulus: same values with br_op = 2.
  - Required: taken = 0.
- bgtz with zero-select:
  - Stimulus: br_op = 4, cmp_out = 001.
  - Required: cmp_zero = 1, taken = 0, pc_F increments by 4.
  - Stimulus: cmp_out = 100.
  - Required: taken = 1.
- jalr under stall:
  - Stimulus: br_op = 10, rs_val = 00004000, pc_D = 00003020, stall = 1 for 3 cycles, then stall = 0.
  - Required: pc_F holds and counters are unchanged during the stall; link_pc = 00003028; pc_F = 00004000 one edge after stall drops; br_cnt unchanged.
- Errors:
  - Stimulus: br_op = 1 with cmp_out = 011.
  - Required: taken = 0 and cmp_err = 1 (sticky); br_cnt +1, tk_cnt +0.
  - Stimulus: j immediately followed by beq.
  - Required: ds_err = 1.
- Saturation:
  - Stimulus: CNT_W = 4, 20 consecutive taken beqs.
  - Required: br_cnt = tk_cnt = 15, held at 15.

Source files
------------

// File: rtl/branch_resolver.sv
// D-stage branch/jump resolver: drives the comparator zero-select, decides redirects,
// owns the fetch PC, tracks delay-slot status and keeps saturating branch statistics.
module branch_resolver #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [3:0]       br_op,
   input  logic [31:0]      pc_D,
   input  logic [15:0]      imm16,
   input  logic [25:0]      idx26,
   input  logic [31:0]      rs_val,
   output logic             cmp_zero,
   input  logic [2:0]       cmp_out,
   output logic [31:0]      pc_F,
   output logic             taken,
   output logic [31:0]      link_pc,
   output logic             is_ds,
   output logic             cmp_err,
   output logic             ds_err,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] tk_cnt
);

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_BEQ  = 4'd1;
   localparam logic [3:0] OP_BNE  = 4'd2;
   localparam logic [3:0] OP_BLEZ = 4'd3;
   localparam logic [3:0] OP_BGTZ = 4'd4;
   localparam logic [3:0] OP_BLTZ = 4'd5;
   localparam logic [3:0] OP_BGEZ = 4'd6;
   localparam logic [3:0] OP_J    = 4'd7;
   localparam logic [3:0] OP_JAL  = 4'd8;
   localparam logic [3:0] OP_JR   = 4'd9;
   localparam logic [3:0] OP_JALR = 4'd10;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      else
         return v + CNT_W'(1);
   endfunction

   logic        cmp_gt;
   logic        cmp_eq;
   logic        cmp_lt;
   logic        cmp_legal;
   logic        is_cond;
   logic        is_ctl;
   logic        cond_hit;
   logic [31:0] pc_plus4;
   logic signed [31:0] br_off;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] target;
   logic [31:0] pc_next;

   assign cmp_gt = cmp_out[2];
   assign cmp_eq = cmp_out[1];
   assign cmp_lt = cmp_out[0];
   assign cmp_legal = (cmp_out == 3'b100) || (cmp_out == 3'b010) || (cmp_out == 3'b001);

   assign is_cond  = (br_op >= OP_BEQ) && (br_op <= OP_BGEZ);
   assign is_ctl   = (br_op >= OP_BEQ) && (br_op <= OP_JALR);
   assign cmp_zero = (br_op >= OP_BLEZ) && (br_op <= OP_BGEZ);

   assign pc_plus4   = pc_D + 32'd4;
   assign link_pc    = pc_D + 32'd8;
   assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};
   assign br_target  = pc_plus4 + $unsigned(br_off);
   assign jmp_target = {pc_plus4[31:28], idx26, 2'b00};

   always_comb begin
      cond_hit = 1'b0;
      case (br_op)
         OP_BEQ:  cond_hit = cmp_eq;
         OP_BNE:  cond_hit = !cmp_eq;
         OP_BLEZ: cond_hit = cmp_lt | cmp_eq;
         OP_BGTZ: cond_hit = cmp_gt;
         OP_BLTZ: cond_hit = cmp_lt;
         OP_BGEZ: cond_hit = cmp_gt | cmp_eq;
         default: cond_hit = 1'b0;
      endcase
   end

   always_comb begin
      taken  = 1'b0;
      target = br_target;
      case (br_op)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
            taken  = cmp_legal & cond_hit;
            target = br_target;
         end
         OP_J, OP_JAL: begin
            taken  = 1'b1;
            target = jmp_target;
         end
         OP_JR, OP_JALR: begin
            taken  = 1'b1;
            target = rs_val;
         end
         OP_NONE: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

   assign pc_next = taken ? target : (pc_F + 32'd4);

   // F/D boundary: everything below advances only on non-stalled edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_F    <= PC_RESET;
         is_ds   <= 1'b0;
         cmp_err <= 1'b0;
         ds_err  <= 1'b0;
         br_cnt  <= '0;
         tk_cnt  <= '0;
      end else if (!stall) begin
         pc_F  <= pc_next;
         is_ds <= is_ctl;
         if (is_ds && is_ctl)
            ds_err <= 1'b1;
         if (is_cond && !cmp_legal)
            cmp_err <= 1'b1;
         if (is_cond) begin
            br_cnt <= sat_inc(br_cnt);
            if (taken)
               tk_cnt <= sat_inc(tk_cnt);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: combinational decision table, redirect table,
// and hand-written sequences for stall, error flags and counter saturation.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [3:0]  br_op;
   logic [31:0] pc_D;
   logic [15:0] imm16;
   logic [25:0] idx26;
   logic [31:0] rs_val;
   logic [2:0]  cmp_out;
   logic        cmp_zero, taken, is_ds, cmp_err, ds_err;
   logic [31:0] pc_F, link_pc;
   logic [15:0] br_cnt, tk_cnt;
   logic        cmp_zero2, taken2, is_ds2, cmp_err2, ds_err2;
   logic [31:0] pc_F2, link_pc2;
   logic [3:0]  br_cnt2, tk_cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   branch_resolver #(.PC_RESET(32'h0000_3000), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .br_op(br_op), .pc_D(pc_D),
      .imm16(imm16), .idx26(idx26), .rs_val(rs_val), .cmp_zero(cmp_zero),
      .cmp_out(cmp_out), .pc_F(pc_F), .taken(taken), .link_pc(link_pc),
      .is_ds(is_ds), .cmp_err(cmp_err), .ds_err(ds_err), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
   );

   branch_resolver #(.PC_RESET(32'h0000_3000), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .stall(stall), .br_op(br_op), .pc_D(pc_D),
      .imm16(imm16), .idx26(idx26), .rs_val(rs_val), .cmp_zero(cmp_zero2),
      .cmp_out(cmp_out), .pc_F(pc_F2), .taken(taken2), .link_pc(link_pc2),
      .is_ds(is_ds2), .cmp_err(cmp_err2), .ds_err(ds_err2), .br_cnt(br_cnt2), .tk_cnt(tk_cnt2)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pcd;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] rs;
      logic [2:0]  cmp;
      logic        tk;
      logic        cz;
      logic [31:0] link;
      logic [31:0] npc;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] pcd,
                               input logic [15:0] imm, input logic [25:0] idx,
                               input logic [31:0] rs, input logic [2:0] cmp,
                               input logic tk, input logic cz,
                               input logic [31:0] link, input logic [31:0] npc);
      vec_t v;
      v.op = op; v.pcd = pcd; v.imm = imm; v.idx = idx; v.rs = rs; v.cmp = cmp;
      v.tk = tk; v.cz = cz; v.link = link; v.npc = npc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] pcd, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs, input logic [2:0] cmp);
      br_op = op; pc_D = pcd; imm16 = imm; idx26 = idx; rs_val = rs; cmp_out = cmp;
   endtask

   vec_t comb_v[19];
   vec_t redir_v[6];

   initial begin
      comb_v[0]  = mk(4'd0,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[1]  = mk(4'd1,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[2]  = mk(4'd1,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[3]  = mk(4'd2,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b100, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[4]  = mk(4'd2,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[5]  = mk(4'd3,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b001, 1'b1, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[6]  = mk(4'd3,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[7]  = mk(4'd4,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[8]  = mk(4'd5,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b001, 1'b1, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[9]  = mk(4'd5,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[10] = mk(4'd6,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b1, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[11] = mk(4'd6,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b001, 1'b0, 1'b1, 32'h0000_1008, 32'h0);
      comb_v[12] = mk(4'd7,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[13] = mk(4'd8,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b111, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[14] = mk(4'd9,  32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
      comb_v[15] = mk(4'd11, 32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[16] = mk(4'd15, 32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[17] = mk(4'd1,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b110, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      comb_v[18] = mk(4'd3,  32'h0000_1000, 16'h0, 26'h0, 32'h0, 3'b101, 1'b0, 1'b1, 32'h0000_1008, 32'h0);

      redir_v[0] = mk(4'd1, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
      redir_v[1] = mk(4'd2, 32'h0000_3000, 16'h7FFF, 26'h0, 32'h0, 3'b100, 1'b1, 1'b0, 32'h0000_3008, 32'h0002_3000);
      redir_v[2] = mk(4'd5, 32'h0000_0010, 16'h8000, 26'h0, 32'h0, 3'b001, 1'b1, 1'b1, 32'h0000_0018, 32'hFFFE_0014);
      redir_v[3] = mk(4'd7, 32'hF000_0010, 16'h0, 26'h3FF_FFFF, 32'h0, 3'b010, 1'b1, 1'b0, 32'hF000_0018, 32'hFFFF_FFFC);
      redir_v[4] = mk(4'd8, 32'h2FFF_FFFC, 16'h0, 26'h000_0001, 32'h0, 3'b010, 1'b1, 1'b0, 32'h3000_0004, 32'h3000_0004);
      redir_v[5] = mk(4'd9, 32'h0000_1000, 16'h0, 26'h0, 32'h1234_5677, 3'b000, 1'b1, 1'b0, 32'h0000_1008, 32'h1234_5677);

      // Reset and free-running fetch.
      reset = 1'b1; stall = 1'b0;
      drive(4'd0, 32'h0, 16'h0, 26'h0, 32'h0, 3'b010);
      tick(); tick();
      chk("rst_pc", pc_F, 32'h0000_3000);
      chk("rst_isds", is_ds, 0);
      chk("rst_cmperr", cmp_err, 0);
      chk("rst_dserr", ds_err, 0);
      chk("rst_brcnt", br_cnt, 0);
      chk("rst_tkcnt", tk_cnt, 0);
      reset = 1'b0;
      tick(); chk("run_pc1", pc_F, 32'h0000_3004);
      tick(); chk("run_pc2", pc_F, 32'h0000_3008);
      tick(); chk("run_pc3", pc_F, 32'h0000_300C);

      // Decision table under stall: nothing registered may move.
      stall = 1'b1;
      for (int i = 0; i < 19; i++) begin
         drive(comb_v[i].op, comb_v[i].pcd, comb_v[i].imm, comb_v[i].idx, comb_v[i].rs, comb_v[i].cmp);
         #1;
         chk($sformatf("tbl%0d_taken", i), taken, comb_v[i].tk);
         chk($sformatf("tbl%0d_cmpzero", i), cmp_zero, comb_v[i].cz);
         chk($sformatf("tbl%0d_link", i), link_pc, comb_v[i].link);
         tick();
      end
      chk("stall_pc", pc_F, 32'h0000_300C);
      chk("stall_brcnt", br_cnt, 0);
      chk("stall_cmperr", cmp_err, 0);
      chk("stall_isds", is_ds, 0);
      chk("stall_dserr", ds_err, 0);
      stall = 1'b0;

      // beq taken, then bne not taken.
      drive(4'd1, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0, 3'b010); #1;
      chk("beq_taken", taken, 1);
      chk("beq_cmpzero", cmp_zero, 0);
      tick();
      chk("beq_pc", pc_F, 32'h0000_3004);
      chk("beq_isds", is_ds, 1);
      chk("beq_brcnt", br_cnt, 1);
      chk("beq_tkcnt", tk_cnt, 1);
      br_op = 4'd0; tick();
      chk("ds_pc", pc_F, 32'h0000_3008);
      chk("ds_isds", is_ds, 0);
      br_op = 4'd2; #1;
      chk("bne_taken", taken, 0);
      tick();
      chk("bne_pc", pc_F, 32'h0000_300C);
      chk("bne_brcnt", br_cnt, 2);
      chk("bne_tkcnt", tk_cnt, 1);
      br_op = 4'd0; tick();

      // bgtz using the zero-select.
      drive(4'd4, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0, 3'b001); #1;
      chk("bgtz_lt_cmpzero", cmp_zero, 1);
      chk("bgtz_lt_taken", taken, 0);
      tick();
      chk("bgtz_lt_pc", pc_F, 32'h0000_3014);
      br_op = 4'd0; tick();
      drive(4'd4, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0, 3'b100); #1;
      chk("bgtz_gt_taken", taken, 1);
      tick();
      chk("bgtz_gt_pc", pc_F, 32'h0000_3004);
      chk("bgtz_brcnt", br_cnt, 4);
      chk("bgtz_tkcnt", tk_cnt, 2);
      br_op = 4'd0; tick();
      chk("pre_jalr_pc", pc_F, 32'h0000_3008);

      // jalr held by a 3-cycle stall.
      drive(4'd10, 32'h0000_3020, 16'h0, 26'h0, 32'h0000_4000, 3'b010);
      stall = 1'b1; #1;
      chk("jalr_taken", taken, 1);
      chk("jalr_link", link_pc, 32'h0000_3028);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("jalr_stall%0d_pc", i), pc_F, 32'h0000_3008);
         chk($sformatf("jalr_stall%0d_brcnt", i), br_cnt, 4);
         chk($sformatf("jalr_stall%0d_isds", i), is_ds, 0);
      end
      stall = 1'b0; tick();
      chk("jalr_pc", pc_F, 32'h0000_4000);
      chk("jalr_brcnt", br_cnt, 4);
      chk("jalr_tkcnt", tk_cnt, 2);
      chk("jalr_isds", is_ds, 1);
      br_op = 4'd0; tick();
      chk("jalr_dserr", ds_err, 0);

      // Illegal comparator result on beq.
      drive(4'd1, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0, 3'b011); #1;
      chk("illegal_taken", taken, 0);
      tick();
      chk("illegal_pc", pc_F, 32'h0000_4008);
      chk("illegal_cmperr", cmp_err, 1);
      chk("illegal_brcnt", br_cnt, 5);
      chk("illegal_tkcnt", tk_cnt, 2);
      br_op = 4'd0; cmp_out = 3'b010; tick();
      chk("sticky_cmperr", cmp_err, 1);

      // j with a beq in its delay slot.
      drive(4'd7, 32'h0000_3020, 16'h0, 26'h000_1400, 32'h0, 3'b010); tick();
      chk("j_pc", pc_F, 32'h0000_5000);
      chk("j_dserr", ds_err, 0);
      drive(4'd1, 32'h0000_5000, 16'h0004, 26'h0, 32'h0, 3'b010); tick();
      chk("dsbeq_dserr", ds_err, 1);
      chk("dsbeq_pc", pc_F, 32'h0000_5014);
      chk("dsbeq_brcnt", br_cnt, 6);
      chk("dsbeq_tkcnt", tk_cnt, 3);

      // Target arithmetic: wrap, large offsets, region bits, unmodified jr.
      for (int i = 0; i < 6; i++) begin
         drive(redir_v[i].op, redir_v[i].pcd, redir_v[i].imm, redir_v[i].idx, redir_v[i].rs, redir_v[i].cmp);
         #1;
         chk($sformatf("redir%0d_taken", i), taken, redir_v[i].tk);
         chk($sformatf("redir%0d_cmpzero", i), cmp_zero, redir_v[i].cz);
         chk($sformatf("redir%0d_link", i), link_pc, redir_v[i].link);
         tick();
         chk($sformatf("redir%0d_pc", i), pc_F, redir_v[i].npc);
      end
      chk("sticky_dserr", ds_err, 1);

      // Reset during a stall, then counter saturation on the narrow instance.
      stall = 1'b1; reset = 1'b1;
      drive(4'd1, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0, 3'b011);
      tick();
      chk("rststall_pc", pc_F, 32'h0000_3000);
      chk("rststall_cmperr", cmp_err, 0);
      chk("rststall_dserr", ds_err, 0);
      chk("rststall_brcnt", br_cnt, 0);
      chk("rststall_sat_brcnt", br_cnt2, 0);
      reset = 1'b0; stall = 1'b0; cmp_out = 3'b010;
      for (int i = 0; i < 14; i++) tick();
      chk("sat14_brcnt", br_cnt2, 14);
      chk("sat14_tkcnt", tk_cnt2, 14);
      tick();
      chk("sat15_brcnt", br_cnt2, 15);
      chk("sat15_tkcnt", tk_cnt2, 15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat20_brcnt", br_cnt2, 15);
      chk("sat20_tkcnt", tk_cnt2, 15);
      chk("wide20_brcnt", br_cnt, 20);
      chk("wide20_tkcnt", tk_cnt, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
